// File: rtl/muxn_pipe.sv
// N-input registered selector with valid/ready handshakes on every channel.
// Direct mode grants channel sel; round-robin mode grants the first valid channel at or after rr_ptr.
module muxn_pipe #(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic                 flush,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_src,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_src;
   logic             r_out_valid;
   logic [SELW-1:0]  r_rr_ptr;

   logic             w_load_en;
   logic             w_cand_found;
   logic [SELW-1:0]  w_cand;
   logic [WIDTH-1:0] w_sel_data;
   logic [WIDTH-1:0] w_ch_data [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign w_ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Flush wins over everything; otherwise accept when the output slot is free or draining.
   assign w_load_en = !flush && (!r_out_valid || out_ready);

   always_comb begin
      int w_idx;
      w_idx        = 0;
      w_cand_found = 1'b0;
      w_cand       = '0;
      if (!mode) begin
         // sel values at or beyond N match no channel and so never grant.
         for (int i = 0; i < N; i++) begin
            if (int'(sel) == i && in_valid[i]) begin
               w_cand_found = 1'b1;
               w_cand       = SELW'(i);
            end
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            for (int j = 0; j < N; j++) begin
               if (j == w_idx && in_valid[j] && !w_cand_found) begin
                  w_cand_found = 1'b1;
                  w_cand       = SELW'(j);
               end
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (!reset && w_load_en && w_cand_found) begin
         for (int i = 0; i < N; i++) begin
            if (int'(w_cand) == i) in_ready[i] = 1'b1;
         end
      end
   end

   assign w_sel_data = w_ch_data[w_cand];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_out_valid <= 1'b0;
         r_rr_ptr    <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_load_en) begin
         if (w_cand_found) begin
            r_out_data  <= w_sel_data;
            r_out_src   <= w_cand;
            r_out_valid <= 1'b1;
            if (mode) begin
               r_rr_ptr <= (int'(w_cand) == N-1) ? '0 : w_cand + 1'b1;
            end
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_muxn_pipe.sv
// Directed bench for muxn_pipe: N=4 main instance plus an N=5 instance for out-of-range sel.
module tb_muxn_pipe;

   logic        clk = 1'b0;
   logic        reset;
   int          n_vec = 0;
   int          n_err = 0;

   // N=4 instance
   logic        mode, flush, out_ready;
   logic [1:0]  sel;
   logic [127:0] in_data;
   logic [3:0]  in_valid, in_ready;
   logic [31:0] out_data;
   logic [1:0]  out_src;
   logic        out_valid;

   // N=5 instance
   logic        mode5, flush5, out_ready5;
   logic [2:0]  sel5;
   logic [159:0] in_data5;
   logic [4:0]  in_valid5, in_ready5;
   logic [31:0] out_data5;
   logic [2:0]  out_src5;
   logic        out_valid5;

   always #5 clk = ~clk;

   muxn_pipe #(.WIDTH(32), .N(4)) u_dut4 (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
   );

   muxn_pipe #(.WIDTH(32), .N(5)) u_dut5 (
      .clk(clk), .reset(reset), .mode(mode5), .sel(sel5), .flush(flush5),
      .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
      .out_data(out_data5), .out_src(out_src5), .out_valid(out_valid5), .out_ready(out_ready5)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ch(input int i, input logic [31:0] v);
      in_data[i*32 +: 32] = v;
   endtask

   task automatic test_reset();
      // Load something so out_valid=1, then hit reset mid-cycle.
      mode = 1'b0; sel = 2'd0; set_ch(0, 32'h0000_1234); in_valid = 4'b0001; out_ready = 1'b0;
      step();
      in_valid = 4'b0000;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_1234) begin
         n_err++; $display("FAIL reset_preload out_valid=%b out_data=%h need 1/00001234", out_valid, out_data);
      end
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin
         n_err++; $display("FAIL reset_async out_valid=%b out_data=%h out_src=%0d need 0/0/0", out_valid, out_data, out_src);
      end
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 4'b0000) begin
         n_err++; $display("FAIL reset_in_ready got=%b need 0000", in_ready);
      end
      step();
      n_vec++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_hold in_ready=%b out_valid=%b need 0000/0", in_ready, out_valid);
      end
      in_valid = 4'b0000;
      reset = 1'b0;
      $display("reset: done");
   endtask

   task automatic test_direct();
      mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
      set_ch(2, 32'hDEAD_BEEF); in_valid = 4'b0100;
      #1;
      n_vec++;
      if (in_ready !== 4'b0100) begin
         n_err++; $display("FAIL direct_in_ready got=%b need 0100", in_ready);
      end
      step();
      in_valid = 4'b0000;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_src !== 2'd2) begin
         n_err++; $display("FAIL direct_out v=%b d=%h s=%0d need 1/deadbeef/2", out_valid, out_data, out_src);
      end
      $display("direct: ch2 -> out_data=%h out_src=%0d", out_data, out_src);
      step();
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 32'hDEAD_BEEF || out_src !== 2'd2) begin
         n_err++; $display("FAIL direct_drain v=%b d=%h s=%0d need 0/deadbeef/2", out_valid, out_data, out_src);
      end
      // N=5: sel=7 never grants, sel=4 is the last valid channel.
      mode5 = 1'b0; sel5 = 3'd7; in_valid5 = 5'b11111; out_ready5 = 1'b1;
      in_data5[4*32 +: 32] = 32'h4444_0004;
      #1;
      n_vec++;
      if (in_ready5 !== 5'b00000) begin
         n_err++; $display("FAIL direct_sel7 in_ready=%b need 00000", in_ready5);
      end
      step();
      n_vec++;
      if (out_valid5 !== 1'b0) begin
         n_err++; $display("FAIL direct_sel7_out out_valid=%b need 0", out_valid5);
      end
      sel5 = 3'd4;
      #1;
      n_vec++;
      if (in_ready5 !== 5'b10000) begin
         n_err++; $display("FAIL direct_sel4 in_ready=%b need 10000", in_ready5);
      end
      step();
      in_valid5 = 5'b00000;
      n_vec++;
      if (out_valid5 !== 1'b1 || out_data5 !== 32'h4444_0004 || out_src5 !== 3'd4) begin
         n_err++; $display("FAIL direct_sel4_out v=%b d=%h s=%0d need 1/44440004/4", out_valid5, out_data5, out_src5);
      end
      $display("direct: N=5 sel=4 -> out_src=%0d", out_src5);
   endtask

   task automatic test_round_robin();
      mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
      for (int i = 0; i < 4; i++) set_ch(i, 32'(i));
      for (int c = 0; c < 8; c++) begin
         step();
         n_vec++;
         if (out_valid !== 1'b1 || out_src !== 2'(c % 4) || out_data !== 32'(c % 4)) begin
            n_err++; $display("FAIL rr_cycle%0d v=%b s=%0d d=%h need 1/%0d/%0d", c, out_valid, out_src, out_data, c % 4, c % 4);
         end
         $display("rr: cycle %0d out_src=%0d", c, out_src);
      end
      in_valid = 4'b0000;
      step();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL rr_drain out_valid=%b need 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      // rr_ptr is 0 here after the round-robin wrap.
      mode = 1'b0; sel = 2'd1; out_ready = 1'b1;
      set_ch(1, 32'hA5A5_A5A5); in_valid = 4'b0010;
      step();
      out_ready = 1'b0; mode = 1'b1; in_valid = 4'b1111;
      for (int i = 0; i < 4; i++) set_ch(i, 32'h100 + 32'(i));
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++;
         if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 32'hA5A5_A5A5 || out_src !== 2'd1) begin
            n_err++; $display("FAIL bp_hold%0d rdy=%b v=%b d=%h s=%0d need 0000/1/a5a5a5a5/1", c, in_ready, out_valid, out_data, out_src);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 4'b0001) begin
         n_err++; $display("FAIL bp_release in_ready=%b need 0001", in_ready);
      end
      step();
      in_valid = 4'b0000;
      n_vec++;
      if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'h100) begin
         n_err++; $display("FAIL bp_next v=%b s=%0d d=%h need 1/0/100", out_valid, out_src, out_data);
      end
      $display("backpressure: released, out_src=%0d", out_src);
      step();
   endtask

   task automatic test_flush();
      // rr_ptr=1: load ch1 so out_src=1, pointer advances to 2.
      mode = 1'b1; out_ready = 1'b1; set_ch(1, 32'h11); in_valid = 4'b0010;
      step();
      set_ch(3, 32'h33); in_valid = 4'b1000; flush = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 4'b0000) begin
         n_err++; $display("FAIL flush_in_ready got=%b need 0000", in_ready);
      end
      step();
      flush = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || out_src !== 2'd1 || out_data !== 32'h11) begin
         n_err++; $display("FAIL flush_out v=%b s=%0d d=%h need 0/1/11", out_valid, out_src, out_data);
      end
      #1;
      n_vec++;
      if (in_ready !== 4'b1000) begin
         n_err++; $display("FAIL flush_after in_ready=%b need 1000", in_ready);
      end
      step();
      in_valid = 4'b0000;
      n_vec++;
      if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 32'h33) begin
         n_err++; $display("FAIL flush_grant v=%b s=%0d d=%h need 1/3/33", out_valid, out_src, out_data);
      end
      $display("flush: ch3 granted after flush, out_src=%0d", out_src);
      step();
   endtask

   task automatic test_mode_switch();
      // rr_ptr=0 here; grant ch1 leaves it at 2.
      mode = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_ch(i, 32'h200 + 32'(i));
      in_valid = 4'b0010;
      step();
      n_vec++;
      if (out_src !== 2'd1 || out_data !== 32'h201) begin
         n_err++; $display("FAIL ms_rr1 s=%0d d=%h need 1/201", out_src, out_data);
      end
      mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
      #1;
      n_vec++;
      if (in_ready !== 4'b0001) begin
         n_err++; $display("FAIL ms_direct_rdy in_ready=%b need 0001", in_ready);
      end
      step();
      n_vec++;
      if (out_src !== 2'd0 || out_data !== 32'h200) begin
         n_err++; $display("FAIL ms_direct s=%0d d=%h need 0/200", out_src, out_data);
      end
      mode = 1'b1; in_valid = 4'b1111;
      #1;
      n_vec++;
      if (in_ready !== 4'b0100) begin
         n_err++; $display("FAIL ms_rr_rdy in_ready=%b need 0100", in_ready);
      end
      step();
      in_valid = 4'b0000;
      n_vec++;
      if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 32'h202) begin
         n_err++; $display("FAIL ms_rr2 v=%b s=%0d d=%h need 1/2/202", out_valid, out_src, out_data);
      end
      $display("mode_switch: rr resumed at out_src=%0d", out_src);
      step();
   endtask

   initial begin
      reset = 1'b1; mode = 1'b0; sel = '0; flush = 1'b0; in_data = '0; in_valid = '0; out_ready = 1'b0;
      mode5 = 1'b0; sel5 = '0; flush5 = 1'b0; in_data5 = '0; in_valid5 = '0; out_ready5 = 1'b0;
      step();
      step();
      reset = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0 || in_ready !== 4'b0000) begin
         n_err++; $display("FAIL init_state v=%b d=%h s=%0d rdy=%b need 0/0/0/0000", out_valid, out_data, out_src, in_ready);
      end
      test_reset();
      test_direct();
      test_round_robin();
      test_backpressure();
      test_flush();
      test_mode_switch();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered output stage and valid/ready handshakes on every input and on the output.
- Two selection modes: direct (explicit sel, for datapath operand/forwarding selection) and round-robin (fair arbitration, for shared write-back/memory request paths).
- Sits between pipeline stages of the MIPS datapath and replaces the fixed 2:1 combinational muxes wherever a stall-aware registered selection point is needed.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels; any value ≥2, non-power-of-2 allowed.
- SELW, $clog2(N), select/index width; localparam derived from N, not overridable.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  0 = direct select, 1 = round-robin.
- sel  in  SELW  channel index used in direct mode; ignored in round-robin mode.
- flush  in  1  synchronous discard of the output register.
- in_data  in  N*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready, combinational, one-hot or zero.
- out_data  out  WIDTH  registered selected data.
- out_src  out  SELW  registered index of the channel that produced out_data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (asynchronous assert, held while high):
  - out_data=0, out_src=0, out_valid=0, rr_ptr=0.
  - in_ready=0 while reset is high.
- load_en = !flush && (!out_valid || out_ready).
- Candidate selection (combinational):
  - Direct mode: the candidate is channel sel if sel<N and in_valid[sel]=1; otherwise there is no candidate. sel≥N never grants.
  - Round-robin mode: scan channels rr_ptr, rr_ptr+1, … modulo N. The first one with in_valid=1 is the candidate.
- in_ready[g]=1 only for the candidate g, and only when load_en=1. All other bits are 0.
- Transfer on a channel occurs when in_valid[g] && in_ready[g]. On the next edge:
  - out_data ← in_data[g].
  - out_src ← g.
  - out_valid ← 1.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Throughput: 1 transfer/cycle when out_ready is held high (simultaneous output drain and input load in the same cycle).
- Output hold:
  - If out_valid=1 and out_ready=0, then out_data, out_src and out_valid are held stable.
  - All in_ready are 0 during the hold.
- Output drain: if out_valid=1, out_ready=1 and there is no candidate, then out_valid ← 0. out_data and out_src keep their last value.
- rr_ptr:
  - Updates only on a round-robin-mode transfer: rr_ptr ← (g+1) mod N, wrapping from N-1 to 0.
  - Unchanged by direct-mode transfers, flush and mode switches.
- flush (priority over everything except reset):
  - Next edge: out_valid ← 0.
  - No input is accepted that cycle (in_ready=0).
  - out_data, out_src and rr_ptr are unchanged.
- Mode and sel are sampled combinationally each cycle. A change takes effect for the grant in that same cycle and never alters an already-registered output.
- Reset asserted mid-transfer: the output is cleared immediately. The pending input transfer is lost; the source must re-present it.
- Inputs must not depend combinationally on in_ready (no valid-after-ready loops). out_valid never depends combinationally on out_ready.

Test Plan:
1. Reset then idle: assert reset mid-cycle with out_valid=1 → out_valid, out_data and out_src go to 0 immediately without a clock edge. in_ready=0 while reset is high.
2. Direct mode, N=4, WIDTH=32, sel=2:
   - Drive in_valid=4'b0100 and ch2 data=32'hDEADBEEF, with out_ready=1 → in_ready=4'b0100. Next cycle out_valid=1, out_data=32'hDEADBEEF, out_src=2.
   - Then sel=5 is not reachable with N=4. Repeat with N=5, sel=7 → no grant, in_ready=0.
3. Round-robin fairness: mode=1, all in_valid=1, ch i data=i, out_ready=1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3, one per cycle. rr_ptr wraps from 3 to 0.
4. Backpressure: out_valid=1 holding 32'hA5A5A5A5, out_ready=0 for 3 cycles while in_valid=4'b1111 → out_data stable and in_ready=0 throughout. On out_ready=1, the next grant is taken in that same cycle.
5. Flush: out_valid=1, out_src=1, flush=1 with in_valid=4'b1000 → next cycle out_valid=0 and ch3 not accepted. The following cycle (flush=0) ch3 is granted and out_src=3. rr_ptr is unaffected by the flush cycle.
6. Mode switch: in round-robin mode, grant ch1 (rr_ptr=2). Switch to direct with sel=0 and grant ch0. Switch back to round-robin with all valid → next grant is ch2, confirming rr_ptr was preserved.
